sseg_capture_decoder: RTL

Receive-side counterpart of the scoreboard's seven-segment encoding path. It samples a multiplexed seven-segment bus (segment lines plus one-hot digit strobes), waits until each digit's pattern has been stable for a programmable number of clocks, and decodes it back to BCD. It then publishes a coherent multi-digit BCD snapshot once every digit has been captured. The block sits on the scoreboard's self-check/readback path, monitoring the display bus driven by the encoders and the digit scanner.

---
 rtl/sseg_capture_decoder_if.sv | 43 ++++
 rtl/sseg_capture_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_capture_decoder_if.sv
// Seven-segment capture bus: raw multiplexed display lines in, decoded BCD snapshot out.
// Latency: none (signal bundle only).
// Backpressure: none; the display bus is free-running and the snapshot is a pulse-qualified register.
// Optional macro SSEG_ERR_CNT_EN adds the err_count readback field.
interface sseg_capture_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          sseg_in;
  logic [DIGITS-1:0]   digit_sel;
  logic [4*DIGITS-1:0] bcd_out;
  logic                frame_valid;
  logic                pattern_err;
`ifdef SSEG_ERR_CNT_EN
  logic [7:0]          err_count;
`endif

`ifdef SSEG_ERR_CNT_EN
  // Display driver side: owns the segment/strobe lines, observes the snapshot.
  modport master (
    output sseg_in, digit_sel,
    input  bcd_out, frame_valid, pattern_err, err_count
  );

  // Capture decoder side.
  modport slave (
    input  sseg_in, digit_sel,
    output bcd_out, frame_valid, pattern_err, err_count
  );
`else
  // Display driver side: owns the segment/strobe lines, observes the snapshot.
  modport master (
    output sseg_in, digit_sel,
    input  bcd_out, frame_valid, pattern_err
  );

  // Capture decoder side.
  modport slave (
    input  sseg_in, digit_sel,
    output bcd_out, frame_valid, pattern_err
  );
`endif

endinterface

// File: rtl/sseg_capture_decoder.sv
// Samples a multiplexed seven-segment bus, captures each digit once stable, publishes a BCD frame.
// Latency: capture STABLE_CYCLES edges after the first sample of a steady pattern; commit one edge later.
// Backpressure: none; the bus cannot be stalled, unstable or illegal patterns are simply not captured.
// Optional macro SSEG_ERR_CNT_EN adds a saturating 8-bit count of illegal-pattern pulses (err_count).
module sseg_capture_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SEG_POLARITY  = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  sseg_capture_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Input stage (polarity-normalised) and the previous sample used for change detection.
  logic [6:0]          s_seg;
  logic [DIGITS-1:0]   s_sel;
  logic [6:0]          p_seg;
  logic [DIGITS-1:0]   p_sel;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [CW-1:0]       cnt_inc;
  logic                capture;

  logic                sel_onehot;
  logic                sample_same;
  logic [4:0]          dec;
  logic                dec_legal;
  logic [3:0]          dec_bcd;

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   seen_set;
  logic                commit;

  logic [4*DIGITS-1:0] bcd_q;
  logic                frame_valid_q;
  logic                pattern_err_q;

  // Returns {legal, bcd} for an active-high segment pattern (bit0=a .. bit6=g).
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7C:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h67:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Register the bus once and keep the prior sample for stability comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg <= '0;
      s_sel <= '0;
      p_seg <= '0;
      p_sel <= '0;
    end else begin
      s_seg <= (SEG_POLARITY != 0) ? bus.sseg_in : ~bus.sseg_in;
      s_sel <= bus.digit_sel;
      p_seg <= s_seg;
      p_sel <= s_sel;
    end
  end

  // Strobe qualification, change detection and pattern decode of the current sample.
  always_comb begin
    sel_onehot  = (s_sel != '0) && ((s_sel & (s_sel - DIGITS'(1))) == '0);
    sample_same = (s_sel == p_sel) && (s_seg == p_seg);
    dec         = decode_seg(s_seg);
    dec_legal   = dec[4];
    dec_bcd     = dec[3:0];
    cnt_inc     = (cnt >= CNT_TARGET) ? CNT_TARGET : cnt + CNT_ONE;
  end

  // State and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: a capture fires on the edge where the counter would reach the target,
  // which lets STABLE_CYCLES=1 capture on the very first sample of any new pattern.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_onehot) begin
          state_nxt = TRACK;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      TRACK: begin
        if (!sel_onehot) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = sample_same ? cnt_inc : CNT_ONE;
        end
      end
      HOLD: begin
        if (!sel_onehot) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!sample_same) begin
          state_nxt = TRACK;
          cnt_nxt   = CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if ((state_nxt == TRACK) && (cnt_nxt == CNT_TARGET)) begin
      capture   = 1'b1;
      state_nxt = HOLD;
    end
  end

  // A legal capture marks its digit (the strobe is one-hot whenever capture is set).
  always_comb begin
    seen_set = (capture && dec_legal) ? s_sel : '0;
    commit   = &seen;
  end

  // Shadow digits collect captures; overwriting an already-seen digit is allowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (seen_set[i]) begin
          shadow[4*i +: 4] <= dec_bcd;
        end
      end
    end
  end

  // Frame bookkeeping: commit when all digits are seen; a same-edge capture lands in the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen          <= '0;
      bcd_q         <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      seen          <= (commit ? '0 : seen) | seen_set;
      frame_valid_q <= commit;
      pattern_err_q <= capture && !dec_legal;
      if (commit) begin
        bcd_q <= shadow;
      end
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pattern_err = pattern_err_q;

`ifdef SSEG_ERR_CNT_EN
  logic [7:0] err_count_q;

  // Saturating count of illegal-pattern pulses, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (capture && !dec_legal && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.err_count = err_count_q;
`endif

endmodule
